// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: register offsets, STATUS field positions and channel state type.
package pwm_capture_pkg;
    localparam logic [7:0] REG_CTRL        = 8'h00;
    localparam logic [7:0] REG_IRQ_EN      = 8'h04;
    localparam logic [7:0] REG_STATUS      = 8'h08;
    localparam logic [7:0] REG_PERIOD_BASE = 8'h10;
    localparam logic [7:0] REG_HIGH_BASE   = 8'h14;
    localparam int         CH_STRIDE       = 8;
    localparam int VALID_LSB   = 0;
    localparam int OVERRUN_LSB = 8;
    localparam int STUCK_LSB   = 16;
    localparam int LEVEL_LSB   = 24;
    typedef enum logic [1:0] {IDLE, ARM, RUN} ch_state_t;
endpackage

// File: rtl/pwm_capture_ch.sv
// pwm_capture_ch: one capture channel measuring period and high time of a PWM input.
//   i_clk, i_rst      clock, async active-high reset
//   i_en              channel enable
//   i_pwm             asynchronous PWM input
//   o_period, o_high  last coherent measurement pair (cycles)
//   o_meas_stb        one-cycle pulse when a new pair is captured
//   o_stuck_stb       one-cycle pulse when the counter saturates in RUN
//   o_level           synchronised input level
module pwm_capture_ch
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_pwm,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_meas_stb,
    output logic             o_stuck_stb,
    output logic             o_level
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic             r_s1, r_s2, r_d, r_fell;
    ch_state_t        r_state;
    logic [CNT_W-1:0] r_cnt, r_hi_lat, r_period, r_high;
    logic             w_rise, w_fall, w_sat, w_run;
    assign w_rise      = r_s2 & ~r_d;
    assign w_fall      = ~r_s2 & r_d;
    assign w_sat       = r_cnt == CNT_MAX;
    assign w_run       = i_en & (r_state == RUN);
    assign o_meas_stb  = w_run & w_rise;
    // A rise in the saturating cycle still yields a valid measurement
    assign o_stuck_stb = w_run & ~w_rise & w_sat;
    assign o_level     = r_s2;
    assign o_period    = r_period;
    assign o_high      = r_high;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_d      <= 1'b0;
            r_fell   <= 1'b0;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hi_lat <= '0;
            r_period <= '0;
            r_high   <= '0;
        end else begin
            r_s1 <= i_pwm;
            r_s2 <= r_s1;
            r_d  <= r_s2;
            if (!i_en) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_hi_lat <= '0;
                r_fell   <= 1'b0;
            end else begin
                r_cnt  <= w_rise ? CNT_W'(1) : w_sat ? r_cnt : r_cnt + 1'b1;
                r_fell <= w_rise ? 1'b0 : r_fell | w_fall;
                if (w_fall) r_hi_lat <= r_cnt;
                if (o_meas_stb) begin
                    r_period <= r_cnt;
                    // No fall since the previous rise: the input stayed high all period
                    r_high   <= r_fell ? r_hi_lat : r_cnt;
                end
                r_state <= w_rise ? RUN : (o_stuck_stb || r_state == IDLE) ? ARM : r_state;
            end
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: multi-channel PWM period/high-time capture with a Wishbone register file.
//   wb_clk_i, wb_rst_i       clock, async active-high reset
//   wbs_*                    Wishbone slave (256-byte window at BASE_ADDR)
//   pwm_in[NUM_CH-1:0]       asynchronous PWM inputs
//   irq                      level interrupt, |(valid & IRQ_EN) registered
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 24,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_CH-1:0] pwm_in,
    output logic              irq
);
    logic [NUM_CH-1:0] r_ctrl, r_irq_en, r_valid, r_overrun, r_stuck;
    logic [NUM_CH-1:0] w_meas, w_stuck, w_level;
    logic [NUM_CH-1:0] w_clr_valid, w_clr_overrun, w_clr_stuck;
    logic [CNT_W-1:0]  w_period [NUM_CH];
    logic [CNT_W-1:0]  w_high [NUM_CH];
    logic              r_ack, r_irq, w_hit, w_acc, w_wr, w_wr_status;
    logic [31:0]       r_dat, w_rdata, w_status;
    logic [7:0]        w_off;
    logic              w_unused;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_capture_ch #(.CNT_W(CNT_W)) u_ch (
            .i_clk      (wb_clk_i),
            .i_rst      (wb_rst_i),
            .i_en       (r_ctrl[c]),
            .i_pwm      (pwm_in[c]),
            .o_period   (w_period[c]),
            .o_high     (w_high[c]),
            .o_meas_stb (w_meas[c]),
            .o_stuck_stb(w_stuck[c]),
            .o_level    (w_level[c])
        );
    end
    assign w_unused    = ^{wbs_dat_i, wbs_sel_i, wbs_adr_i};
    assign w_hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // Accept only while ack is low, so acks are separated by at least one idle cycle
    assign w_acc       = w_hit & ~r_ack;
    assign w_wr        = w_acc & wbs_we_i;
    assign w_off       = {wbs_adr_i[7:2], 2'b00};
    assign w_wr_status = w_wr & (w_off == REG_STATUS);
    assign w_clr_valid   = (w_wr_status & wbs_sel_i[0]) ? wbs_dat_i[VALID_LSB +: NUM_CH] : '0;
    assign w_clr_overrun = (w_wr_status & wbs_sel_i[1]) ? wbs_dat_i[OVERRUN_LSB +: NUM_CH] : '0;
    assign w_clr_stuck   = (w_wr_status & wbs_sel_i[2]) ? wbs_dat_i[STUCK_LSB +: NUM_CH] : '0;
    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign irq         = r_irq;
    always_comb begin
        w_status = '0;
        w_status[VALID_LSB +: NUM_CH]   = r_valid;
        w_status[OVERRUN_LSB +: NUM_CH] = r_overrun;
        w_status[STUCK_LSB +: NUM_CH]   = r_stuck;
        w_status[LEVEL_LSB +: NUM_CH]   = w_level;
        w_rdata = w_off == REG_CTRL   ? 32'(r_ctrl) :
                  w_off == REG_IRQ_EN ? 32'(r_irq_en) :
                  w_off == REG_STATUS ? w_status : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_off == REG_PERIOD_BASE + 8'(CH_STRIDE * i)) w_rdata = 32'(w_period[i]);
            if (w_off == REG_HIGH_BASE + 8'(CH_STRIDE * i)) w_rdata = 32'(w_high[i]);
        end
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_irq     <= 1'b0;
            r_ctrl    <= '0;
            r_irq_en  <= '0;
            r_valid   <= '0;
            r_overrun <= '0;
            r_stuck   <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_acc ? w_rdata : '0;
            if (w_wr && w_off == REG_CTRL && wbs_sel_i[0]) r_ctrl <= wbs_dat_i[NUM_CH-1:0];
            if (w_wr && w_off == REG_IRQ_EN && wbs_sel_i[0]) r_irq_en <= wbs_dat_i[NUM_CH-1:0];
            // Hardware set is OR-ed in after the clear so it wins a same-cycle W1C
            r_valid   <= (r_valid & ~w_clr_valid) | w_meas;
            r_overrun <= (r_overrun & ~w_clr_overrun) | (w_meas & r_valid);
            r_stuck   <= (r_stuck & ~w_clr_stuck) | w_stuck;
            r_irq     <= |(r_valid & r_irq_en);
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture (NUM_CH=4, CNT_W=8).
module tb_pwm_capture;
    localparam logic [31:0] BASE = 32'h3000_0000;
    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic [3:0]  pwm_lvl;
    logic        irq;
    int          n_chk = 0;
    int          n_fail = 0;

    pwm_capture #(.NUM_CH(4), .CNT_W(8), .BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_dat_i(dat_i),
        .wbs_adr_i(adr),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .pwm_in   (pwm_lvl),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic acked);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        acked = 1'b0;
        rd = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acked = 1'b1;
                rd = dat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic        acked;
        xfer(1'b1, BASE + 32'(off), d, s, rd, acked);
        chk("wr_ack", 32'(acked), 1);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] mask, input logic [31:0] exp);
        logic [31:0] rd;
        logic        acked;
        xfer(1'b0, BASE + 32'(off), '0, 4'hF, rd, acked);
        if (!acked) chk({tag, "_ack"}, 32'(acked), 1);
        else chk(tag, rd & mask, exp);
    endtask

    // Drives n periods of p cycles, high for the first h, starting at a falling clock edge
    task automatic wave(input int ch, input int p, input int h, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            pwm_lvl[ch] = 1'b1;
            repeat (h) @(negedge clk);
            pwm_lvl[ch] = 1'b0;
            repeat (p - h) @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        acked;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; dat_i = '0; adr = '0; pwm_lvl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_irq", 32'(irq), 0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_status", REG_STATUS_OFF(), 32'hFFFF_FFFF, 0);
        rd_chk("rst_ctrl", 8'h00, 32'hFFFF_FFFF, 0);

        // 1: basic measurement, first rise only arms
        wr(8'h00, 32'h1, 4'hF);
        wave(0, 100, 30, 1);
        rd_chk("t1_arm_no_valid", 8'h08, 32'h1, 0);
        wave(0, 100, 30, 3);
        rd_chk("t1_period0", 8'h10, 32'hFFFF_FFFF, 100);
        rd_chk("t1_high0", 8'h14, 32'hFFFF_FFFF, 30);
        rd_chk("t1_valid0", 8'h08, 32'h1, 1);

        // 2: interrupt follows valid with one cycle of latency
        wr(8'h04, 32'h1, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_irq_on", 32'(irq), 1);
        wr(8'h08, 32'h1, 4'h1);
        chk("t2_irq_lag", 32'(irq), 1);
        @(posedge clk);
        #1;
        chk("t2_irq_off", 32'(irq), 0);
        rd_chk("t2_valid_clr", 8'h08, 32'h1, 0);
        rd_chk("t2_ovr_kept", 8'h08, 32'h100, 32'h100);
        wr(8'h00, 32'h0, 4'hF);
        rd_chk("t2_period_kept", 8'h10, 32'hFFFF_FFFF, 100);
        wr(8'h08, 32'h00FF_FFFF, 4'h7);

        // 3: overrun on second unacknowledged measurement
        wr(8'h00, 32'h1, 4'hF);
        wave(0, 100, 30, 2);
        rd_chk("t3_one_meas", 8'h08, 32'h101, 32'h001);
        wave(0, 100, 30, 1);
        rd_chk("t3_overrun", 8'h08, 32'h101, 32'h101);
        wr(8'h08, 32'h100, 4'h2);
        rd_chk("t3_ovr_clr", 8'h08, 32'h101, 32'h001);
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h08, 32'h00FF_FFFF, 4'h7);

        // 4: stuck-high input saturates the 8-bit counter, then re-arms
        wr(8'h00, 32'h2, 4'h1);
        wave(1, 50, 20, 3);
        pwm_lvl[1] = 1'b1;
        repeat (250) @(posedge clk);
        rd_chk("t4_not_stuck_yet", 8'h08, 32'h2_0000, 0);
        repeat (10) @(posedge clk);
        rd_chk("t4_stuck1", 8'h08, 32'h2_0000, 32'h2_0000);
        rd_chk("t4_period1_kept", 8'h18, 32'hFFFF_FFFF, 50);
        rd_chk("t4_high1", 8'h1C, 32'hFFFF_FFFF, 20);
        rd_chk("t4_level1", 8'h08, 32'h0200_0000, 32'h0200_0000);
        wr(8'h08, 32'h00FF_FFFF, 4'h7);
        pwm_lvl[1] = 1'b0;
        wave(1, 60, 25, 1);
        rd_chk("t4_rearm_no_valid", 8'h08, 32'h2, 0);
        wave(1, 60, 25, 2);
        rd_chk("t4_resume_valid", 8'h08, 32'h2, 32'h2);
        rd_chk("t4_resume_period", 8'h18, 32'hFFFF_FFFF, 60);
        rd_chk("t4_resume_high", 8'h1C, 32'hFFFF_FFFF, 25);
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h08, 32'h00FF_FFFF, 4'h7);

        // 5: hardware set beats same-cycle W1C; unmapped and foreign accesses
        wr(8'h00, 32'h4, 4'h1);
        wave(2, 40, 10, 2);
        pwm_lvl[2] = 1'b1;
        @(negedge clk);
        wr(8'h08, 32'h4, 4'h1);
        rd_chk("t5_set_wins", 8'h08, 32'h4, 32'h4);
        wr(8'h08, 32'h4, 4'h1);
        rd_chk("t5_w1c", 8'h08, 32'h4, 0);
        rd_chk("t5_unmapped80", 8'h80, 32'hFFFF_FFFF, 0);
        rd_chk("t5_unmapped0c", 8'h0C, 32'hFFFF_FFFF, 0);
        xfer(1'b0, 32'h3000_0100, '0, 4'hF, rd, acked);
        chk("t5_foreign_noack", 32'(acked), 0);
        pwm_lvl[2] = 1'b0;
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h08, 32'h00FF_FFFF, 4'h7);

        // 6: reset in the middle of activity on all channels
        wr(8'h04, 32'hF, 4'h1);
        wr(8'h00, 32'hF, 4'h1);
        fork
            wave(0, 37, 11, 8);
            wave(1, 50, 20, 6);
            wave(2, 64, 40, 5);
            wave(3, 90, 40, 4);
            begin
                repeat (250) @(posedge clk);
                #2;
                chk("t6_irq_before", 32'(irq), 1);
                rst = 1'b1;
                #1;
                chk("t6_rst_irq", 32'(irq), 0);
                chk("t6_rst_ack", 32'(ack), 0);
                chk("t6_rst_dat", dat_o, 0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        rd_chk("t6_ctrl", 8'h00, 32'hFFFF_FFFF, 0);
        rd_chk("t6_irq_en", 8'h04, 32'hFFFF_FFFF, 0);
        rd_chk("t6_status", 8'h08, 32'hFFFF_FFFF, 0);
        for (int c = 0; c < 4; c++) begin
            rd_chk("t6_period", 8'(8'h10 + 8 * c), 32'hFFFF_FFFF, 0);
            rd_chk("t6_high", 8'(8'h14 + 8 * c), 32'hFFFF_FFFF, 0);
        end
        wr(8'h00, 32'h1, 4'h0);
        rd_chk("t6_sel_ignored", 8'h00, 32'hFFFF_FFFF, 0);
        wr(8'h00, 32'h1, 4'h1);
        wave(0, 50, 20, 2);
        rd_chk("t6_single_meas", 8'h08, 32'h101, 32'h001);
        rd_chk("t6_period0", 8'h10, 32'hFFFF_FFFF, 50);
        rd_chk("t6_high0", 8'h14, 32'hFFFF_FFFF, 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    function automatic logic [7:0] REG_STATUS_OFF();
        return 8'h08;
    endfunction
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Multi-channel PWM measurement block; the receive-side counterpart of the team's PWM generator.
- Samples external PWM waveforms on user GPIO inputs and measures period and high time of each, in wb_clk_i cycles.
- Exposes results through a Wishbone slave register file and raises one interrupt line.
- Instantiated in user_project_wrapper alongside the generator; inputs come from io_in, so the matching io_oeb bits are tied high.

Parameters:
- NUM_CH, 4, number of capture channels (1..8).
- CNT_W, 24, measurement counter width (8..32).
- BASE_ADDR, 32'h3000_0000, Wishbone base; the block decodes adr[31:8] == BASE_ADDR[31:8].

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- pwm_in  in  NUM_CH  asynchronous PWM inputs.
- irq  out  1  level interrupt.

Behaviour:
- Reset: wbs_ack_o=0, wbs_dat_o=0, irq=0. All registers, counters, flags and synchronisers clear to 0.
- Input path: 2-flop synchroniser, then an edge-detect flop. An edge is detected 3 cycles after it arrives at the pin.
- Counter rules, per enabled channel:
  - cnt increments every cycle and saturates at 2^CNT_W-1.
  - On a detected rise: cnt<=1.
  - On a detected fall: hi_lat<=cnt.
  - Result: PERIOD=P and HIGH=H cycles, for a waveform of period P high for H.
- Channel states: IDLE (disabled) -> ARM (enabled, waiting for the first rise) -> RUN.
  - ARM -> RUN on the first rise. No measurement is produced for this rise.
  - RUN, each rise: PERIOD<=cnt and HIGH<=hi_lat in the same cycle (coherent pair). valid[ch]<=1. If valid[ch] was already 1, overrun[ch]<=1.
  - RUN, cnt reaches saturation: stuck[ch]<=1, go to ARM. PERIOD and HIGH are not updated.
  - Clearing the enable bit from any state: go to IDLE, clear cnt and hi_lat. PERIOD, HIGH and the flags are retained.
- Duty edge cases: a constant-level input produces only stuck. A rise with no fall since the previous rise reports HIGH=PERIOD, i.e. hi_lat is forced to cnt when no fall was seen.
- Register map (offsets from base, word access):
  - 0x00 CTRL, RW: [NUM_CH-1:0] channel enable.
  - 0x04 IRQ_EN, RW: [NUM_CH-1:0] valid-interrupt enable.
  - 0x08 STATUS: [7:0] valid, [15:8] overrun, [23:16] stuck, [31:24] synchronised input level.
    - Flag fields are write-1-to-clear. The level field is read-only.
    - Bits at or above NUM_CH in each field read 0.
  - 0x10+8*ch PERIOD, RO, zero-extended.
  - 0x14+8*ch HIGH, RO, zero-extended.
  - Unmapped offsets inside the 256-byte window: ack, read 0, writes ignored.
- Byte lanes: writes honour wbs_sel_i per byte on CTRL, IRQ_EN and STATUS.
- Wishbone timing:
  - wbs_ack_o asserts for exactly 1 cycle, in the cycle after stb&cyc&address-hit with ack low. It is then low for at least 1 cycle, so at most one ack every 2 cycles.
  - Read data is registered and valid with ack.
  - No ack for addresses outside the window.
- Simultaneous events: a hardware flag set wins over a same-cycle W1C of that bit. A same-cycle rise and disable resolves to disable.
- irq = |(valid & IRQ_EN), registered (1-cycle latency). It stays asserted until software clears valid.
- Reset asserted mid-operation: immediate return to the reset state. No partial measurement survives.

Decomposition:
- Package pwm_capture_pkg holds:
  - register offsets (CTRL, IRQ_EN, STATUS, PERIOD_BASE, HIGH_BASE, CH_STRIDE);
  - STATUS field LSB positions;
  - the channel state enum (IDLE, ARM, RUN).
- Sub-module pwm_capture_ch, instantiated NUM_CH times, contains: synchroniser, edge detect, state machine, cnt and hi_lat. Outputs: period, high, meas_stb, stuck_stb, level.
- The top level holds the Wishbone decode, CTRL/IRQ_EN, flag registers and irq.

Test Plan:
1. Enable ch0, drive period 100 / high 30 for 4 periods -> PERIOD0=100, HIGH0=30, valid[0]=1. The first rise produces no measurement.
2. IRQ_EN[0]=1, valid set -> irq high; write STATUS=0x1 -> valid[0]=0, irq low 1 cycle later.
3. Keep measuring without clearing valid -> overrun[0]=1 after the second measurement; W1C 0x100 clears it.
4. CNT_W=8, hold ch1 high -> stuck[1]=1 after 255 cycles in RUN, PERIOD1 unchanged, level bit 25 reads 1. Resume toggling -> one rise to re-arm, then valid measurements.
5. Drive a rise in the same cycle as a W1C of valid[2] -> valid[2] remains 1. Read an unmapped offset 0x80 -> ack, data 0. Access a foreign address -> no ack.
6. Assert wb_rst_i mid-measurement on all channels -> all outputs and registers 0. After re-enable, the first rise only arms.
